// File: rtl/pulse_decoder.sv
// pulse_decoder
//   Re-expands an encoded request index into a one-hot strobe. Each accepted
//   code drives exactly one y_out bit for PULSE_LEN cycles, followed by
//   GAP_LEN forced all-zero cycles.
//
//   Optional macro DEC_SKID_EN: adds a one-entry skid register so a code can
//   be accepted while a strobe or gap is in progress. That code is then
//   launched back-to-back, with no IDLE cycle in between.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   code_in     encoded index (CODE_W bits)
//   code_valid  code_in valid
//   code_ready  block can accept code_in this cycle (combinational)
//   y_out       registered one-hot strobe, all zero when not driving
//   busy        registered, high in DRIVE or GAP
//   done        registered one-cycle pulse on the final DRIVE cycle
module pulse_decoder #(
  parameter int CODE_W    = 2,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CODE_W-1:0]      code_in,
  input  logic                   code_valid,
  output logic                   code_ready,
  output logic [(1<<CODE_W)-1:0] y_out,
  output logic                   busy,
  output logic                   done
);

  localparam int N      = 1 << CODE_W;
  localparam int CMAX   = (PULSE_LEN > GAP_LEN) ? ((PULSE_LEN > 2) ? PULSE_LEN : 2)
                                                : ((GAP_LEN > 2) ? GAP_LEN : 2);
  localparam int CNT_W  = $clog2(CMAX);
  localparam int GAP_M1 = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               drain_pt;   // last cycle of a strobe/gap sequence
  logic               have_next;  // a code is available to chain directly
  logic [CODE_W-1:0]  next_code;

  assign accept   = code_valid && code_ready;
  assign drain_pt = (cnt == '0) &&
                    ((state == GAP) || (state == DRIVE && GAP_LEN == 0));

`ifdef DEC_SKID_EN
  logic              skid_full;
  logic [CODE_W-1:0] skid_code;

  assign code_ready = rst_n && !skid_full;
  // On the drain cycle a full skid takes priority. With the skid empty, a
  // code accepted on that same cycle chains straight into DRIVE rather than
  // being parked, so it can never be stranded in the skid while IDLE.
  assign have_next  = skid_full || (accept && state != IDLE);
  assign next_code  = skid_full ? skid_code : code_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_full <= 1'b0;
      skid_code <= '0;
    end else if (drain_pt && skid_full) begin
      skid_full <= 1'b0;
    end else if (accept && state != IDLE && !drain_pt) begin
      skid_full <= 1'b1;
      skid_code <= code_in;
    end
  end
`else
  assign code_ready = rst_n && (state == IDLE);
  assign have_next  = 1'b0;
  assign next_code  = code_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      y_out <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= DRIVE;
            y_out <= N'(1) << code_in;
            cnt   <= CNT_W'(PULSE_LEN - 1);
            busy  <= 1'b1;
            done  <= (PULSE_LEN == 1);
          end
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt  <= cnt - 1'b1;
            done <= (cnt == CNT_W'(1));
          end else if (GAP_LEN > 0) begin
            state <= GAP;
            cnt   <= CNT_W'(GAP_M1);
            y_out <= '0;
          end else if (have_next) begin
            y_out <= N'(1) << next_code;
            cnt   <= CNT_W'(PULSE_LEN - 1);
            done  <= (PULSE_LEN == 1);
          end else begin
            state <= IDLE;
            y_out <= '0;
            busy  <= 1'b0;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (have_next) begin
            state <= DRIVE;
            y_out <= N'(1) << next_code;
            cnt   <= CNT_W'(PULSE_LEN - 1);
            done  <= (PULSE_LEN == 1);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          y_out <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_decoder.sv
// Directed bench for pulse_decoder with CODE_W=2, PULSE_LEN=3, GAP_LEN=1.
// The skid scenarios are compiled in only when DEC_SKID_EN is defined.
module tb_pulse_decoder;

  logic       clk;
  logic       rst_n;
  logic [1:0] code_in;
  logic       code_valid;
  logic       code_ready;
  logic [3:0] y_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  pulse_decoder #(.CODE_W(2), .PULSE_LEN(3), .GAP_LEN(1)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .y_out(y_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // y_out, busy, done in one call
  task automatic chk_out(input string tag, input logic [3:0] y, input logic b, input logic d);
    chk({tag, ".y"}, y_out, y);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".done"}, done, d);
  endtask

  initial begin
    // 1. reset with a valid code presented
    rst_n = 1'b0; code_valid = 1'b1; code_in = 2'd2;
    #1;
    chk("rst.ready0", code_ready, 1'b0);
    step(); chk_out("rst.c1", 4'b0000, 1'b0, 1'b0); chk("rst.ready1", code_ready, 1'b0);
    step(); chk_out("rst.c2", 4'b0000, 1'b0, 1'b0); chk("rst.ready2", code_ready, 1'b0);
    code_valid = 1'b0; rst_n = 1'b1;
    #1;
    chk("rst.ready_rel", code_ready, 1'b1);

    // 2. single code 2
    code_in = 2'd2; code_valid = 1'b1;
    step(); code_valid = 1'b0; code_in = 2'd1;
    chk_out("one.d1", 4'b0100, 1'b1, 1'b0); chk("one.ready_busy", code_ready, 1'b0);
    step(); chk_out("one.d2", 4'b0100, 1'b1, 1'b0);
    step(); chk_out("one.d3", 4'b0100, 1'b1, 1'b1);
    step(); chk_out("one.gap", 4'b0000, 1'b1, 1'b0);
    step(); chk_out("one.idle", 4'b0000, 1'b0, 1'b0); chk("one.ready_idle", code_ready, 1'b1);

    // 3. sweep 0..3 with valid held: one strobe every 5 cycles
    code_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      code_in = 2'(c);
      step(); code_in = 2'(3 - c);  // ignored while not ready
      chk_out($sformatf("sw%0d.d1", c), 4'(1 << c), 1'b1, 1'b0);
      step(); chk_out($sformatf("sw%0d.d2", c), 4'(1 << c), 1'b1, 1'b0);
      step(); chk_out($sformatf("sw%0d.d3", c), 4'(1 << c), 1'b1, 1'b1);
      step(); chk_out($sformatf("sw%0d.gap", c), 4'b0000, 1'b1, 1'b0);
      step(); chk_out($sformatf("sw%0d.idle", c), 4'b0000, 1'b0, 1'b0);
    end
    code_valid = 1'b0;

    // 4. reset during the 2nd DRIVE cycle of code 3
    code_in = 2'd3; code_valid = 1'b1;
    step(); code_valid = 1'b0;
    chk_out("mid.d1", 4'b1000, 1'b1, 1'b0);
    step(); chk_out("mid.d2", 4'b1000, 1'b1, 1'b0);
    rst_n = 1'b0;
    step(); chk_out("mid.rst", 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1; chk("mid.ready", code_ready, 1'b1);
    step(); chk_out("mid.idle", 4'b0000, 1'b0, 1'b0);
    code_in = 2'd1; code_valid = 1'b1;
    step(); code_valid = 1'b0;
    chk_out("mid.again", 4'b0010, 1'b1, 1'b0);
    step(); step(); step(); step();
    chk_out("mid.back_idle", 4'b0000, 1'b0, 1'b0);

`ifdef DEC_SKID_EN
    // 5. code 1 then code 3 into the skid: back-to-back strobes
    code_in = 2'd1; code_valid = 1'b1;
    step(); chk_out("sk.a1", 4'b0010, 1'b1, 1'b0); chk("sk.ready_a1", code_ready, 1'b1);
    code_in = 2'd3;
    step(); code_valid = 1'b0;
    chk_out("sk.a2", 4'b0010, 1'b1, 1'b0); chk("sk.ready_full", code_ready, 1'b0);
    step(); chk_out("sk.a3", 4'b0010, 1'b1, 1'b1);
    step(); chk_out("sk.gap", 4'b0000, 1'b1, 1'b0);
    step(); chk_out("sk.b1", 4'b1000, 1'b1, 1'b0);
    step(); chk_out("sk.b2", 4'b1000, 1'b1, 1'b0);
    step(); chk_out("sk.b3", 4'b1000, 1'b1, 1'b1);
    step(); chk_out("sk.gap2", 4'b0000, 1'b1, 1'b0);
    step(); chk_out("sk.idle", 4'b0000, 1'b0, 1'b0);

    // 6. third code stalls while the skid is full
    code_in = 2'd0; code_valid = 1'b1;
    step(); chk_out("s3.a1", 4'b0001, 1'b1, 1'b0);
    code_in = 2'd1;
    step(); code_in = 2'd2;
    chk("s3.ready_a2", code_ready, 1'b0);
    step(); chk_out("s3.a3", 4'b0001, 1'b1, 1'b1); chk("s3.ready_a3", code_ready, 1'b0);
    step(); chk_out("s3.gap", 4'b0000, 1'b1, 1'b0); chk("s3.ready_drain", code_ready, 1'b0);
    step(); chk_out("s3.b1", 4'b0010, 1'b1, 1'b0); chk("s3.ready_b1", code_ready, 1'b1);
    step(); code_valid = 1'b0;
    chk_out("s3.b2", 4'b0010, 1'b1, 1'b0); chk("s3.ready_b2", code_ready, 1'b0);
    step(); chk_out("s3.b3", 4'b0010, 1'b1, 1'b1);
    step(); chk_out("s3.gap2", 4'b0000, 1'b1, 1'b0);
    step(); chk_out("s3.c1", 4'b0100, 1'b1, 1'b0);
    step(); chk_out("s3.c2", 4'b0100, 1'b1, 1'b0);
    step(); chk_out("s3.c3", 4'b0100, 1'b1, 1'b1);
    step(); chk_out("s3.gap3", 4'b0000, 1'b1, 1'b0);
    step(); chk_out("s3.idle", 4'b0000, 1'b0, 1'b0);
    step(); chk_out("s3.no_dup", 4'b0000, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
